// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 8-point FFT datapath: gathers serial samples into a frame,
// launches it, captures results into credit-managed output buffers and re-serializes them.
module fft_frame_ctrl #(
    parameter int NUM_POINT = 8,
    parameter int DATA_W    = 32,
    parameter int FFT_LAT   = 3,
    parameter int OUT_BUFS  = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*DATA_W-1:0]             in_data,
    output logic                            fft_in_valid,
    output logic [NUM_POINT*2*DATA_W-1:0]   fft_in_data,
    input  logic [NUM_POINT*2*DATA_W-1:0]   fft_out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*DATA_W-1:0]             out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic [15:0]                     frame_cnt
);

    localparam int SMP_W = 2 * DATA_W;
    localparam int IDX_W = $clog2(NUM_POINT);
    localparam int PTR_W = (OUT_BUFS > 1) ? $clog2(OUT_BUFS) : 1;
    localparam int CRD_W = $clog2(OUT_BUFS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_BUFS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(OUT_BUFS);
    localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);

    logic [SMP_W-1:0]    in_buf_r  [NUM_POINT];
    logic [SMP_W-1:0]    out_buf_r [OUT_BUFS][NUM_POINT];
    logic [IDX_W-1:0]    wr_idx_r;
    logic                frame_full_r;
    logic [FFT_LAT-1:0]  lat_sr_r;
    logic [CRD_W-1:0]    credits_r;
    logic [OUT_BUFS-1:0] out_full_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [IDX_W-1:0]    rd_idx_r;
    logic [15:0]         frame_cnt_r;

    logic                in_hs_s;
    logic                launch_s;
    logic                capture_s;
    logic                out_valid_s;
    logic                out_hs_s;
    logic                out_done_s;
    logic [FFT_LAT-1:0]  lat_sr_s;
    logic [CRD_W-1:0]    credits_s;
    logic [OUT_BUFS-1:0] out_full_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_ONE;
    endfunction

    assign in_hs_s     = in_valid & ~frame_full_r;
    assign launch_s    = frame_full_r & (credits_r != {CRD_W{1'b0}});
    assign capture_s   = lat_sr_r[FFT_LAT-1];
    assign out_valid_s = out_full_r[rd_ptr_r];
    assign out_hs_s    = out_valid_s & out_ready;
    assign out_done_s  = out_hs_s & (rd_idx_r == LAST_IDX);

    // Next-state for the latency pipe, credit pool and buffer-full flags.
    always_comb begin
        lat_sr_s    = lat_sr_r << 1;
        lat_sr_s[0] = launch_s;
        credits_s   = credits_r;
        if (launch_s && !out_done_s) begin
            credits_s = credits_r - CRD_ONE;
        end else if (!launch_s && out_done_s) begin
            credits_s = credits_r + CRD_ONE;
        end else begin
            credits_s = credits_r;
        end
        // Credits guarantee capture and free never target the same buffer.
        out_full_s = out_full_r;
        if (capture_s) begin
            out_full_s[wr_ptr_r] = 1'b1;
        end else begin
            out_full_s = out_full_s;
        end
        if (out_done_s) begin
            out_full_s[rd_ptr_r] = 1'b0;
        end else begin
            out_full_s = out_full_s;
        end
    end

    // Control state: collect index, launch pipe, credits, buffer pointers, frame counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_r     <= {IDX_W{1'b0}};
            frame_full_r <= 1'b0;
            lat_sr_r     <= {FFT_LAT{1'b0}};
            credits_r    <= CRD_INIT;
            out_full_r   <= {OUT_BUFS{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            rd_idx_r     <= {IDX_W{1'b0}};
            frame_cnt_r  <= 16'd0;
        end else begin
            if (in_hs_s) begin
                wr_idx_r <= (wr_idx_r == LAST_IDX) ? {IDX_W{1'b0}} : wr_idx_r + IDX_ONE;
            end
            if (in_hs_s && (wr_idx_r == LAST_IDX)) begin
                frame_full_r <= 1'b1;
            end else if (launch_s) begin
                frame_full_r <= 1'b0;
            end
            lat_sr_r   <= lat_sr_s;
            credits_r  <= credits_s;
            out_full_r <= out_full_s;
            if (capture_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (out_hs_s) begin
                rd_idx_r <= (rd_idx_r == LAST_IDX) ? {IDX_W{1'b0}} : rd_idx_r + IDX_ONE;
            end
            if (out_done_s) begin
                rd_ptr_r    <= next_ptr(rd_ptr_r);
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    // Sample and result storage; contents are don't-care out of reset.
    always_ff @(posedge clock) begin
        if (in_hs_s) begin
            in_buf_r[wr_idx_r] <= in_data;
        end
        if (capture_s) begin
            for (int k = 0; k < NUM_POINT; k++) begin
                out_buf_r[wr_ptr_r][k] <= fft_out_data[k*SMP_W +: SMP_W];
            end
        end
    end

    // Present the collected frame to the datapath as a flat vector.
    always_comb begin
        fft_in_data = {(NUM_POINT*SMP_W){1'b0}};
        for (int k = 0; k < NUM_POINT; k++) begin
            fft_in_data[k*SMP_W +: SMP_W] = in_buf_r[k];
        end
    end

    assign in_ready     = ~frame_full_r;
    assign fft_in_valid = launch_s;
    assign out_valid    = out_valid_s;
    assign out_data     = out_buf_r[rd_ptr_r][rd_idx_r];
    assign out_last     = out_valid_s & (rd_idx_r == LAST_IDX);
    assign busy         = (wr_idx_r != {IDX_W{1'b0}}) | frame_full_r |
                          (lat_sr_r != {FFT_LAT{1'b0}}) | (|out_full_r);
    assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a 3-cycle DFT datapath model behind it.
module tb_fft_frame_ctrl;

    localparam int NP = 8;
    localparam int DW = 32;
    localparam real PI = 3.14159265358979323846;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   in_data;
    logic              fft_in_valid;
    logic [NP*2*DW-1:0] fft_in_data;
    logic [NP*2*DW-1:0] fft_out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_data;
    logic              out_last;
    logic              busy;
    logic [15:0]       frame_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int t0;

    int          launch_cyc [$];
    int          beat_cyc   [$];
    logic [63:0] beat_data  [$];
    logic        beat_last  [$];

    logic [NP*2*DW-1:0] dp1, dp2, dp3;

    fft_frame_ctrl dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fft_in_valid(fft_in_valid), .fft_in_data(fft_in_data),
        .fft_out_data(fft_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference DFT, X[k] = sum x[n] e^{-j 2 pi k n / N}, rounded to 16.16.
    function automatic logic [63:0] dft_bin(input logic [NP*2*DW-1:0] fr, input int k);
        real re, im, ph;
        int  xr, xi;
        re = 0.0;
        im = 0.0;
        for (int n = 0; n < NP; n++) begin
            xr = $signed(fr[n*64+32 +: 32]);
            xi = $signed(fr[n*64 +: 32]);
            ph = 2.0 * PI * real'(k * n) / real'(NP);
            re = re + real'(xr) * $cos(ph) + real'(xi) * $sin(ph);
            im = im + real'(xi) * $cos(ph) - real'(xr) * $sin(ph);
        end
        return {32'($rtoi($floor(re + 0.5))), 32'($rtoi($floor(im + 0.5)))};
    endfunction

    // Datapath stand-in: three register stages, never stalls.
    always @(posedge clock) begin
        if (fft_in_valid) begin
            for (int k = 0; k < NP; k++) dp1[k*64 +: 64] <= dft_bin(fft_in_data, k);
        end else begin
            dp1 <= '0;
        end
        dp2 <= dp1;
        dp3 <= dp2;
    end
    assign fft_out_data = dp3;

    always @(negedge clock) begin
        if (!reset) begin
            if (fft_in_valid) launch_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] d);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        do begin
            acc = in_ready;
            @(posedge clock);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push_impulse(input logic [31:0] re);
        for (int k = 0; k < NP; k++) push((k == 0) ? {re, 32'h0} : 64'h0);
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget);
        int g;
        g = 0;
        while (frame_cnt !== target && g < budget) begin
            step(1);
            g++;
        end
        check("frame_cnt", 64'(frame_cnt), 64'(target));
    endtask

    task automatic clear_mon();
        launch_cyc.delete();
        beat_cyc.delete();
        beat_data.delete();
        beat_last.delete();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fft_in_valid", 64'(fft_in_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step(2);
        @(negedge clock);
        reset = 1'b0;
        step(1);

        // Reset while a partial frame is being collected.
        push(64'h0001_0000_0000_0000);
        push(64'h0002_0000_0000_0000);
        push(64'h0003_0000_0000_0000);
        idle();
        check("t1_busy_before", 64'(busy), 64'd1);
        do_reset();

        // Impulse frame, back-to-back, downstream always ready.
        clear_mon();
        t0 = cyc;
        push_impulse(32'h0001_0000);
        idle();
        wait_frames(16'd1, 40);
        step(1);
        check("t2_launch_count", 64'(launch_cyc.size()), 64'd1);
        check("t2_launch_cycle", 64'(launch_cyc[0] - t0), 64'd8);
        check("t2_beat_count", 64'(beat_cyc.size()), 64'd8);
        check("t2_first_beat", 64'(beat_cyc[0] - t0), 64'd12);
        check("t2_last_beat", 64'(beat_cyc[7] - t0), 64'd19);
        for (int i = 0; i < beat_data.size(); i++) begin
            check($sformatf("t2_bin%0d", i), beat_data[i], 64'h0001_0000_0000_0000);
            check($sformatf("t2_last%0d", i), 64'(beat_last[i]), (i == 7) ? 64'd1 : 64'd0);
        end
        check("t2_busy_after", 64'(busy), 64'd0);

        // Downstream stalled: two frames buffered, third held for lack of credit.
        clear_mon();
        out_ready = 1'b0;
        push_impulse(32'h0001_0000);
        push_impulse(32'h0002_0000);
        push_impulse(32'h0003_0000);
        idle();
        step(3);
        check("t3_launches_held", 64'(launch_cyc.size()), 64'd2);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_fft_in_valid", 64'(fft_in_valid), 64'd0);
        check("t3_out_valid", 64'(out_valid), 64'd1);
        check("t3_hold_a", out_data, 64'h0001_0000_0000_0000);
        step(3);
        check("t3_hold_b", out_data, 64'h0001_0000_0000_0000);
        check("t3_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        wait_frames(16'd4, 80);
        step(1);
        check("t3_launch_count", 64'(launch_cyc.size()), 64'd3);
        check("t3_late_launch", 64'(launch_cyc[2] - beat_cyc[7]), 64'd1);
        check("t3_beat_count", 64'(beat_cyc.size()), 64'd24);
        check("t3_beats_span", 64'(beat_cyc[23] - beat_cyc[0]), 64'd23);
        for (int i = 0; i < beat_data.size(); i++) begin
            check($sformatf("t3_beat%0d", i), beat_data[i], {32'((i / 8 + 1) << 16), 32'h0});
        end

        // Sustained streaming of four ramp frames from a fresh reset.
        do_reset();
        clear_mon();
        t0 = cyc;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NP; k++) push({32'(k << 16), 32'h0});
        end
        idle();
        wait_frames(16'd4, 80);
        check("t4_launch_count", 64'(launch_cyc.size()), 64'd4);
        check("t4_first_launch", 64'(launch_cyc[0] - t0), 64'd8);
        for (int i = 1; i < launch_cyc.size(); i++) begin
            check($sformatf("t4_launch_gap%0d", i), 64'(launch_cyc[i] - launch_cyc[i-1]), 64'd9);
        end
        check("t4_beat_count", 64'(beat_cyc.size()), 64'd32);
        for (int i = 0; i < beat_data.size(); i++) begin
            check($sformatf("t4_re%0d", i), 64'(beat_data[i][63:32]),
                  64'(((i % 8) == 0) ? 32'h001C_0000 : 32'hFFFC_0000));
            check($sformatf("t4_last%0d", i), 64'(beat_last[i]), ((i % 8) == 7) ? 64'd1 : 64'd0);
            case (i % 8)
                0: check($sformatf("t4_im%0d", i), 64'(beat_data[i][31:0]), 64'h0000_0000);
                2: check($sformatf("t4_im%0d", i), 64'(beat_data[i][31:0]), 64'h0004_0000);
                4: check($sformatf("t4_im%0d", i), 64'(beat_data[i][31:0]), 64'h0000_0000);
                6: check($sformatf("t4_im%0d", i), 64'(beat_data[i][31:0]), 64'hFFFC_0000);
                default: ;
            endcase
        end

        // Reset after five accepted samples; only the fresh frame may appear.
        for (int k = 0; k < 5; k++) push({32'h7777_0000, 32'h0000_1234});
        idle();
        do_reset();
        clear_mon();
        step(2);
        check("t5_no_stale_beats", 64'(beat_cyc.size()), 64'd0);
        t0 = cyc;
        push_impulse(32'h0005_0000);
        idle();
        wait_frames(16'd1, 40);
        check("t5_launch_count", 64'(launch_cyc.size()), 64'd1);
        check("t5_launch_cycle", 64'(launch_cyc[0] - t0), 64'd8);
        check("t5_beat_count", 64'(beat_cyc.size()), 64'd8);
        for (int i = 0; i < beat_data.size(); i++) begin
            check($sformatf("t5_bin%0d", i), beat_data[i], 64'h0005_0000_0000_0000);
        end

        // Launch in the same cycle as the credit-returning last beat.
        clear_mon();
        out_ready = 1'b0;
        push_impulse(32'h000A_0000);
        idle();
        step(6);
        out_ready = 1'b1;
        step(7);
        out_ready = 1'b0;
        check("t6_partial_beats", 64'(beat_cyc.size()), 64'd7);
        push(64'h000B_0000_0000_0000);
        for (int k = 1; k < NP - 1; k++) push(64'h0);
        idle();
        step(2);
        push(64'h0);
        idle();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t6_launch_count", 64'(launch_cyc.size()), 64'd2);
        check("t6_beat_count", 64'(beat_cyc.size()), 64'd8);
        check("t6_coincide", 64'(launch_cyc[1] - beat_cyc[7]), 64'd0);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd2);
        push_impulse(32'h000C_0000);
        push_impulse(32'h000D_0000);
        idle();
        step(6);
        check("t6_credit_limit", 64'(launch_cyc.size()), 64'd3);
        check("t6_fft_in_valid", 64'(fft_in_valid), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        wait_frames(16'd5, 80);
        step(1);
        check("t6_total_launch", 64'(launch_cyc.size()), 64'd4);
        check("t6_total_beats", 64'(beat_cyc.size()), 64'd32);
        for (int i = 8; i < beat_data.size(); i++) begin
            check($sformatf("t6_beat%0d", i), beat_data[i], {32'((i / 8 + 10) << 16), 32'h0});
        end
        check("t6_busy_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
